// File: rtl/spart_pkg.sv
// Shared SPART definitions: controller states, I/O port register addresses and
// the baud divisor helper used by both the SPART and its bus controller.
package spart_pkg;

  typedef enum logic [2:0] {
    StCfgLo,
    StCfgHi,
    StRun,
    StRxRd,
    StTxWr
  } state_e;

  localparam logic [1:0] IO_XFER   = 2'b00;
  localparam logic [1:0] REG_RD    = 2'b01;
  localparam logic [1:0] LD_DIV_LO = 2'b10;
  localparam logic [1:0] LD_DIV_HI = 2'b11;

  // Divisor for the 16x oversampling baud generator, truncating division.
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] br_cfg);
    int unsigned baud;
    case (br_cfg)
      2'b00:   baud = 32'd4800;
      2'b01:   baud = 32'd9600;
      2'b10:   baud = 32'd19200;
      default: baud = 32'd38400;
    endcase
    return 16'(clk_hz / (32'd16 * baud) - 32'd1);
  endfunction

endpackage

// File: rtl/spart_div_lut.sv
// Baud select to 16-bit divisor lookup; all four entries fold to constants.
module spart_div_lut
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic [1:0]  br_cfg,
  output logic [15:0] div
);

  localparam logic [15:0] Div4800  = baud_div(CLK_HZ, 2'b00);
  localparam logic [15:0] Div9600  = baud_div(CLK_HZ, 2'b01);
  localparam logic [15:0] Div19200 = baud_div(CLK_HZ, 2'b10);
  localparam logic [15:0] Div38400 = baud_div(CLK_HZ, 2'b11);

  // Select the precomputed divisor.
  always_comb begin
    div = Div38400;
    case (br_cfg)
      2'b00:   div = Div4800;
      2'b01:   div = Div9600;
      2'b10:   div = Div19200;
      default: div = Div38400;
    endcase
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART bus-side controller: programs the baud divisor after reset, then
// arbitrates the shared I/O port between receive reads and transmit writes.
// Optional feature macro: SPART_ECHO_EN (loop received bytes back to transmit).
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] databus_out,
  output logic       databus_oe,
  input  logic [7:0] databus_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cfg_done
);

  state_e      state_q, state_d;
  logic [1:0]  br_q;
  logic [7:0]  hold_q;
  logic        hold_valid_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        cfg_done_q;

  logic [1:0]  lut_sel;
  logic [15:0] div;
  logic        echo_load;
  logic        hold_free;
  logic        tx_accept;

  // CFG_LO writes the live selection (and latches it); CFG_HI reuses the latched one.
  assign lut_sel = (state_q == StCfgLo) ? br_cfg : br_q;

  spart_div_lut #(
    .CLK_HZ(CLK_HZ)
  ) u_div_lut (
    .br_cfg(lut_sel),
    .div   (div)
  );

`ifdef SPART_ECHO_EN
  assign echo_load = rx_valid_q && !hold_valid_q;
`else
  assign echo_load = 1'b0;
`endif

  // An echo claims the empty hold register ahead of the tx port.
  assign hold_free = !hold_valid_q && !echo_load;
  assign tx_accept = tx_valid && hold_free;

  // Next-state selection; RUN resolves reconfig > receive > transmit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCfgLo: state_d = StCfgHi;
      StCfgHi: state_d = StRun;
      StRun: begin
        if (br_cfg != br_q) begin
          state_d = StCfgLo;
        end else if (rda) begin
          state_d = StRxRd;
        end else if (tbr && hold_valid_q) begin
          state_d = StTxWr;
        end
      end
      StRxRd:  state_d = StRun;
      StTxWr:  state_d = StRun;
      default: state_d = StCfgLo;
    endcase
  end

  // Bus and stream outputs decoded from state; held at zero while reset is asserted.
  always_comb begin
    iocs        = 1'b0;
    iorw        = 1'b0;
    ioaddr      = IO_XFER;
    databus_out = 8'h00;
    databus_oe  = 1'b0;
    unique case (state_q)
      StCfgLo: begin
        iocs        = 1'b1;
        ioaddr      = LD_DIV_LO;
        databus_oe  = 1'b1;
        databus_out = div[7:0];
      end
      StCfgHi: begin
        iocs        = 1'b1;
        ioaddr      = LD_DIV_HI;
        databus_oe  = 1'b1;
        databus_out = div[15:8];
      end
      StRxRd: begin
        iocs = 1'b1;
        iorw = 1'b1;
      end
      StTxWr: begin
        iocs        = 1'b1;
        databus_oe  = 1'b1;
        databus_out = hold_q;
      end
      default: ;
    endcase
    tx_ready = hold_free;
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    cfg_done = cfg_done_q;
    if (!rst) begin
      iocs        = 1'b0;
      iorw        = 1'b0;
      ioaddr      = IO_XFER;
      databus_out = 8'h00;
      databus_oe  = 1'b0;
      tx_ready    = 1'b0;
      rx_data     = 8'h00;
      rx_valid    = 1'b0;
      cfg_done    = 1'b0;
    end
  end

  // State, baud latch and configuration status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StCfgLo;
      br_q       <= 2'b00;
      cfg_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StCfgLo) begin
        br_q <= br_cfg;
      end
      if (state_q == StCfgHi) begin
        cfg_done_q <= 1'b1;
      end else if (state_q == StRun && state_d == StCfgLo) begin
        cfg_done_q <= 1'b0;
      end
    end
  end

  // Receive capture: data sampled at the end of RX_RD, valid pulses one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= (state_q == StRxRd);
      if (state_q == StRxRd) begin
        rx_data_q <= databus_in;
      end
    end
  end

  // Transmit hold register; survives reconfiguration, emptied by TX_WR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end else if (echo_load) begin
      hold_q       <= rx_data_q;
      hold_valid_q <= 1'b1;
    end else if (tx_accept) begin
      hold_q       <= tx_data;
      hold_valid_q <= 1'b1;
    end else if (state_q == StTxWr) begin
      hold_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl at CLK_HZ = 100 MHz.
// Inputs change just after a rising edge or at the falling edge; outputs are
// compared at the falling edge.
module tb_spart_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus_out;
  logic       databus_oe;
  logic [7:0] databus_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cfg_done;

  logic [12:0] bus;
  logic [2:0]  st;
  logic [12:0] exp_bus;
  logic [2:0]  exp_st;
  int tests = 0;
  int failed = 0;

  spart_bus_ctrl #(
    .CLK_HZ(100_000_000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .rda        (rda),
    .tbr        (tbr),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus_out(databus_out),
    .databus_oe (databus_oe),
    .databus_in (databus_in),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cfg_done   (cfg_done)
  );

  always #5 clk = ~clk;

  // {iocs, iorw, ioaddr, oe, data} and {cfg_done, tx_ready, rx_valid}
  assign bus = {iocs, iorw, ioaddr, databus_oe, databus_out};
  assign st  = {cfg_done, tx_ready, rx_valid};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0;
    databus_in = 8'h00; tx_data = 8'h00; tx_valid = 1'b0;
    step(); step();
    @(negedge clk);
    exp_bus = 13'h0000;
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL reset_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b000;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL reset_status: got %b want %b", st, exp_st); end
    tests++; if (rx_data !== 8'h00) begin failed++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
  endtask

  task automatic test_cfg();
    step(); rst = 1'b1;
    @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b10, 1'b1, 8'h8A};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL cfg_lo_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b010;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL cfg_lo_status: got %b want %b", st, exp_st); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b11, 1'b1, 8'h02};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL cfg_hi_bus: got %h want %h", bus, exp_bus); end
    tests++; if (cfg_done !== 1'b0) begin failed++; $display("FAIL cfg_hi_done: got %b want 0", cfg_done); end
    step(); @(negedge clk);
    exp_bus = 13'h0000;
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL cfg_run_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b110;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL cfg_run_status: got %b want %b", st, exp_st); end
  endtask

  task automatic test_rx();
    rda = 1'b1; databus_in = 8'h5A;
    step(); rda = 1'b0;
    @(negedge clk);
    exp_bus = {1'b1, 1'b1, 2'b00, 1'b0, 8'h00};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL rx_rd_bus: got %h want %h", bus, exp_bus); end
    tests++; if (rx_valid !== 1'b0) begin failed++; $display("FAIL rx_rd_valid: got %b want 0", rx_valid); end
    step(); @(negedge clk);
    exp_st = 3'b111;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL rx_pulse_status: got %b want %b", st, exp_st); end
    tests++; if (rx_data !== 8'h5A) begin failed++; $display("FAIL rx_pulse_data: got %h want 5a", rx_data); end
    tests++; if (iocs !== 1'b0) begin failed++; $display("FAIL rx_idle_iocs: got %b want 0", iocs); end
    step(); @(negedge clk);
    exp_st = 3'b110;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL rx_pulse_end: got %b want %b", st, exp_st); end
    tests++; if (rx_data !== 8'h5A) begin failed++; $display("FAIL rx_data_hold: got %h want 5a", rx_data); end
  endtask

  task automatic test_tx();
    tx_valid = 1'b1; tx_data = 8'h41; tbr = 1'b1;
    step(); tx_valid = 1'b0; tx_data = 8'h00;
    @(negedge clk);
    exp_bus = 13'h0000;
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL tx_load_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b100;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL tx_ready_drop: got %b want %b", st, exp_st); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b00, 1'b1, 8'h41};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL tx_wr_bus: got %h want %h", bus, exp_bus); end
    step(); tbr = 1'b0;
    @(negedge clk);
    exp_bus = 13'h0000;
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL tx_after_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b110;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL tx_ready_back: got %b want %b", st, exp_st); end
  endtask

  task automatic test_back_to_back();
    tx_valid = 1'b1; tx_data = 8'h33;
    step(); tx_valid = 1'b0; rda = 1'b1; tbr = 1'b1; databus_in = 8'hC3;
    @(negedge clk);
    exp_st = 3'b100;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL b2b_held: got %b want %b", st, exp_st); end
    step(); rda = 1'b0;
    @(negedge clk);
    exp_bus = {1'b1, 1'b1, 2'b00, 1'b0, 8'h00};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL b2b_rx_first: got %h want %h", bus, exp_bus); end
    step(); @(negedge clk);
    exp_bus = 13'h0000;
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL b2b_idle: got %h want %h", bus, exp_bus); end
    exp_st = 3'b101;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL b2b_rx_pulse: got %b want %b", st, exp_st); end
    tests++; if (rx_data !== 8'hC3) begin failed++; $display("FAIL b2b_rx_data: got %h want c3", rx_data); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b00, 1'b1, 8'h33};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL b2b_tx_wr: got %h want %h", bus, exp_bus); end
    step(); tbr = 1'b0;
    @(negedge clk);
    exp_st = 3'b110;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL b2b_end: got %b want %b", st, exp_st); end
  endtask

  task automatic test_reconfig();
    tx_valid = 1'b1; tx_data = 8'h77;
    step(); tx_valid = 1'b0; br_cfg = 2'b11; tbr = 1'b1;
    @(negedge clk);
    exp_st = 3'b100;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL recfg_run: got %b want %b", st, exp_st); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b10, 1'b1, 8'hA1};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL recfg_lo_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b000;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL recfg_done_drop: got %b want %b", st, exp_st); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b11, 1'b1, 8'h00};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL recfg_hi_bus: got %h want %h", bus, exp_bus); end
    step(); @(negedge clk);
    exp_st = 3'b100;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL recfg_done_back: got %b want %b", st, exp_st); end
    tests++; if (iocs !== 1'b0) begin failed++; $display("FAIL recfg_run_iocs: got %b want 0", iocs); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b00, 1'b1, 8'h77};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL recfg_tx_wr: got %h want %h", bus, exp_bus); end
    step(); tbr = 1'b0;
    @(negedge clk);
    exp_st = 3'b110;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL recfg_end: got %b want %b", st, exp_st); end
  endtask

  task automatic test_reset_mid();
    tx_valid = 1'b1; tx_data = 8'h55;
    step(); tx_valid = 1'b0; br_cfg = 2'b00;
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b10, 1'b1, 8'h15};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL rmid_lo_bus: got %h want %h", bus, exp_bus); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b11, 1'b1, 8'h05};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL rmid_hi_bus: got %h want %h", bus, exp_bus); end
    rst = 1'b0;
    step(); @(negedge clk);
    exp_bus = 13'h0000;
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL rmid_reset_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b000;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL rmid_reset_status: got %b want %b", st, exp_st); end
    step(); rst = 1'b1;
    @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b10, 1'b1, 8'h15};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL rmid_restart_bus: got %h want %h", bus, exp_bus); end
    exp_st = 3'b010;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL rmid_hold_cleared: got %b want %b", st, exp_st); end
    tests++; if (rx_data !== 8'h00) begin failed++; $display("FAIL rmid_rx_cleared: got %h want 00", rx_data); end
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b11, 1'b1, 8'h05};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL rmid_restart_hi: got %h want %h", bus, exp_bus); end
    step(); @(negedge clk);
    exp_st = 3'b110;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL rmid_done: got %b want %b", st, exp_st); end
  endtask

`ifdef SPART_ECHO_EN
  task automatic test_echo();
    rda = 1'b1; databus_in = 8'h10;
    step(); rda = 1'b0;
    step(); @(negedge clk);
    exp_st = 3'b101;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL echo_pulse: got %b want %b", st, exp_st); end
    step(); tbr = 1'b1;
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b00, 1'b1, 8'h10};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL echo_tx_wr: got %h want %h", bus, exp_bus); end
    step(); tbr = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h99;
    step(); tx_valid = 1'b0; rda = 1'b1; databus_in = 8'h20;
    step(); rda = 1'b0;
    step(); @(negedge clk);
    tests++; if (rx_data !== 8'h20) begin failed++; $display("FAIL echo_full_rx: got %h want 20", rx_data); end
    tbr = 1'b1;
    step(); @(negedge clk);
    exp_bus = {1'b1, 1'b0, 2'b00, 1'b1, 8'h99};
    tests++; if (bus !== exp_bus) begin failed++; $display("FAIL echo_dropped: got %h want %h", bus, exp_bus); end
    step(); tbr = 1'b0;
    @(negedge clk);
    exp_st = 3'b110;
    tests++; if (st !== exp_st) begin failed++; $display("FAIL echo_end: got %b want %b", st, exp_st); end
  endtask
`endif

  initial begin
    test_reset();
    test_cfg();
    test_rx();
    test_tx();
    test_back_to_back();
    test_reconfig();
    test_reset_mid();
`ifdef SPART_ECHO_EN
    test_echo();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
